// File: rtl/booth_mul_8bits_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM encoding,
// operand width, iteration count and the true-sign helper.
package booth_mul_8bits_pkg;

    localparam int DATA_W     = 8;
    localparam int ITER_COUNT = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Sign of the mathematically exact add/subtract result. When the 8-bit
    // result overflows, its MSB is inverted relative to the true sign, so the
    // overflow flag flips it back. b_msb is the MSB of the effective (possibly
    // inverted) second operand.
    function automatic logic true_sign(input logic a_msb,
                                       input logic b_msb,
                                       input logic r_msb);
        logic ovf;
        ovf = (a_msb == b_msb) && (r_msb != a_msb);
        return r_msb ^ ovf;
    endfunction

endpackage

// File: rtl/booth_mul_8bits_add_sub.sv
// 8-bit two's-complement adder/subtractor: result = a + b (sel=0) or a - b (sel=1).
module add_sub_8bits
    import booth_mul_8bits_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] b_eff_s;

    // Invert b for subtract; the carry-in of sel completes the two's complement.
    always_comb begin
        b_eff_s = sel ? ~b : b;
        result  = a + b_eff_s + {{(DATA_W-1){1'b0}}, sel};
    end

endmodule

// File: rtl/booth_mul_8bits.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed.
// One iteration per RUN cycle, 8 iterations, then a one-cycle DONE state.
module booth_mul_8bits
    import booth_mul_8bits_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [2*DATA_W-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic                q1_q, q1_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [2*DATA_W-1:0] product_q, product_d;

    logic [DATA_W-1:0]   addsub_res_s;
    logic [DATA_W-1:0]   step_sum_s;
    logic                step_sign_s;
    logic [DATA_W-1:0]   ac_shift_s;
    logic [DATA_W-1:0]   q_shift_s;
    logic                q1_shift_s;

    // Operand a is the accumulator, b the multiplicand; Q[0] selects subtract
    // exactly in the {Q[0],Q_1}=10 case and add in the 01 case.
    add_sub_8bits u_add_sub (
        .a      (ac_q),
        .b      (m_q),
        .sel    (q_q[0]),
        .result (addsub_res_s)
    );

    // One Booth step: optional add/subtract, then arithmetic right shift of
    // {AC,Q,Q_1} with the true sign entering AC[7].
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01, 2'b10: begin
                step_sum_s  = addsub_res_s;
                step_sign_s = true_sign(ac_q[DATA_W-1],
                                        m_q[DATA_W-1] ^ q_q[0],
                                        addsub_res_s[DATA_W-1]);
            end
            default: begin
                step_sum_s  = ac_q;
                step_sign_s = ac_q[DATA_W-1];
            end
        endcase
        ac_shift_s = {step_sign_s, step_sum_s[DATA_W-1:1]};
        q_shift_s  = {step_sum_s[0], q_q[DATA_W-1:1]};
        q1_shift_s = q_q[0];
    end

    // Next-state logic for the FSM, datapath registers and registered outputs.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        ac_d      = ac_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = A;
                    q_d     = B;
                    ac_d    = {DATA_W{1'b0}};
                    q1_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                ac_d  = ac_shift_s;
                q_d   = q_shift_s;
                q1_d  = q1_shift_s;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = {ac_shift_s, q_shift_s};
                end else begin
                    busy_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= {DATA_W{1'b0}};
            ac_q      <= {DATA_W{1'b0}};
            q_q       <= {DATA_W{1'b0}};
            q1_q      <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {(2*DATA_W){1'b0}};
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            ac_q      <= ac_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_8bits.sv
// Self-checking bench for booth_mul_8bits: directed corners, start/reset
// robustness, randomized products and back-to-back throughput.
module tb_booth_mul_8bits;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks;
    int errors;

    booth_mul_8bits dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (a_in),
        .B       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain signed integer multiplication truncated to 16 bits.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return 16'(ia * ib);
    endfunction

    // Stimulus only: launch one multiply and observe 15 cycles after the start edge.
    // lat is the index k of the first done sample (sample k follows edge k).
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                          output logic [15:0] prod, output int lat,
                          output int busy_cnt, output int done_cnt);
        lat = -1;
        prod = 16'h0000;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        a_in = a;
        b_in = b;
        start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    prod = product;
                end
            end
            if (scramble) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat, bc, dc;
        do_mul(8'd3, 8'd5, 1'b0, p, lat, bc, dc);
        checks++;
        if (p !== 16'h000F) begin
            errors++;
            $display("FAIL basic_product: got %h want 000F", p);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: done after edge %0d want 8", lat);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d want 8", bc);
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL basic_done_pulses: got %0d want 1", dc);
        end
        checks++;
        if (product !== 16'h000F) begin
            errors++;
            $display("FAIL basic_product_hold: got %h want 000F", product);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ta [7];
        logic [7:0]  tb [7];
        logic [15:0] te [7];
        logic [15:0] p;
        int lat, bc, dc;
        ta = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F};
        tb = '{8'h80, 8'h80, 8'h01, 8'hB3, 8'h7F, 8'h01, 8'h7F};
        te = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000, 16'hC080, 16'hFF80, 16'h3F01};
        for (int i = 0; i < 7; i++) begin
            do_mul(ta[i], tb[i], 1'b1, p, lat, bc, dc);
            checks++;
            if (p !== te[i] || dc !== 1) begin
                errors++;
                $display("FAIL corner_%0d: A=%h B=%h product=%h pulses=%0d, want %h pulses=1",
                         i, ta[i], tb[i], p, dc, te[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc, bc, lat;
        logic [15:0] p;
        dc = 0; bc = 0; lat = -1; p = 16'h0000;
        @(negedge clk);
        a_in = 8'd25;
        b_in = 8'hFD;
        start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 2) begin
                start = 1'b1;
                a_in = 8'h9C;
                b_in = 8'h4D;
            end
            if (k == 5) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dc++;
                if (lat < 0) begin
                    lat = k;
                    p = product;
                end
            end
        end
        checks++;
        if (p !== 16'hFFB5) begin
            errors++;
            $display("FAIL start_ignored_product: got %h want FFB5", p);
        end
        checks++;
        if (dc !== 1 || lat !== 8 || bc !== 8) begin
            errors++;
            $display("FAIL start_ignored_timing: pulses=%0d lat=%0d busy=%0d want 1 8 8", dc, lat, bc);
        end
    endtask

    task automatic test_reset_mid_run();
        int dc, bc, lat;
        logic [15:0] p;
        dc = 0;
        @(negedge clk);
        a_in = 8'h55;
        b_in = 8'h33;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b product=%h, want 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        checks++;
        if (dc !== 0) begin
            errors++;
            $display("FAIL reset_abort_no_done: activity cycles=%0d want 0", dc);
        end
        do_mul(8'hF9, 8'd9, 1'b0, p, lat, bc, dc);
        checks++;
        if (p !== 16'hFFC1 || dc !== 1 || lat !== 8) begin
            errors++;
            $display("FAIL reset_recover: product=%h pulses=%0d lat=%0d want FFC1 1 8", p, dc, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] p;
        int lat, bc, dc;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_mul(a, b, 1'b1, p, lat, bc, dc);
            checks++;
            if (p !== ref_mul(a, b) || dc !== 1 || lat !== 8) begin
                errors++;
                $display("FAIL random_%0d: A=%h B=%h product=%h pulses=%0d lat=%0d, want %h 1 8",
                         i, a, b, p, dc, lat, ref_mul(a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [4];
        logic [7:0] pb [4];
        int done_cyc [4];
        int idx;
        for (int i = 0; i < 4; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
            done_cyc[i] = 0;
        end
        idx = 0;
        @(negedge clk);
        a_in = pa[0];
        b_in = pb[0];
        start = 1'b1;
        for (int cyc = 1; cyc <= 60 && idx < 4; cyc++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (product !== ref_mul(pa[idx], pb[idx])) begin
                    errors++;
                    $display("FAIL b2b_product_%0d: got %h want %h", idx, product, ref_mul(pa[idx], pb[idx]));
                end
                done_cyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    a_in = pa[idx];
                    b_in = pb[idx];
                end else begin
                    start = 1'b0;
                end
            end else if (busy) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
        start = 1'b0;
        checks++;
        if (idx !== 4) begin
            errors++;
            $display("FAIL b2b_timeout: completed %0d want 4", idx);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (done_cyc[i] - done_cyc[i-1] !== 10) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d want 10", i, done_cyc[i] - done_cyc[i-1]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        start = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        test_reset();
        test_basic();
        test_corners();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
